// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for the shift-add unsigned multiplier.
// Owns the HI/LO pair; runs MULTU/MADDU, serves MTHI/MTLO and MFHI/MFLO.
module mult_seq_ctrl #(
    parameter int unsigned ITER           = 32,
    parameter logic [5:0]  MULTU_CODE     = 6'b011001,
    parameter logic [5:0]  MADDU_CODE     = 6'b011100,
    parameter logic [5:0]  MULTU_OUT_CODE = 6'b111111,
    parameter logic [5:0]  MADDU_OUT_CODE = 6'b111110,
    parameter logic [5:0]  IDLE_CODE      = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    output logic [5:0]  mul_signal,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned   CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          op_madd;
    logic          op_madd_nx;
    logic [31:0]   a_nx;
    logic [31:0]   b_nx;
    logic [31:0]   hi_nx;
    logic [31:0]   lo_nx;
    logic          is_op;
    logic          accept;
    logic [63:0]   acc_sum;

    // Only MULTU/MADDU start the sequencer, and only from IDLE.
    assign is_op   = (req_funct == MULTU_CODE) || (req_funct == MADDU_CODE);
    assign accept  = (state == S_IDLE) && req_valid && is_op;
    // MADDU accumulation; carry out of bit 63 is dropped.
    assign acc_sum = {hi, lo} + mul_result;

    // State, counter, operand latches and the architectural HI/LO pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_madd <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            op_madd <= op_madd_nx;
            mul_a   <= a_nx;
            mul_b   <= b_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
        end
    end

    // Next-state logic and per-state multiplier control / handshake outputs.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        op_madd_nx = op_madd;
        a_nx       = mul_a;
        b_nx       = mul_b;
        hi_nx      = hi;
        lo_nx      = lo;
        mul_signal = IDLE_CODE;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                // An MT write lands at the accept edge, so a following
                // MADDU accumulates onto the freshly written value.
                if (mt_we) begin
                    if (mt_sel) hi_nx = mt_data;
                    else        lo_nx = mt_data;
                end
                if (accept) begin
                    a_nx       = req_a;
                    b_nx       = req_b;
                    op_madd_nx = (req_funct == MADDU_CODE);
                    cnt_nx     = '0;
                    state_nx   = S_RUN;
                end
            end
            S_RUN: begin
                mul_signal = op_madd ? MADDU_CODE : MULTU_CODE;
                cnt_nx     = cnt + ONE;
                if (cnt == LAST) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                mul_signal = op_madd ? MADDU_OUT_CODE : MULTU_OUT_CODE;
                state_nx   = S_WRITE;
            end
            S_WRITE: begin
                done = 1'b1;
                if (op_madd) {hi_nx, lo_nx} = acc_sum;
                else         {hi_nx, lo_nx} = mul_result;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        req_ready = ~busy;
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed bench for mult_seq_ctrl with a
// behavioural shift-add multiplier attached.
module tb_mult_seq_ctrl;

    localparam int         ITER    = 32;
    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_MADDU = 6'b011100;
    localparam logic [5:0] C_MOUT  = 6'b111111;
    localparam logic [5:0] C_AOUT  = 6'b111110;
    localparam logic [5:0] C_IDLE  = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic [5:0]  mul_signal;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .busy       (busy),
        .done       (done),
        .mul_signal (mul_signal),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mt_we      (mt_we),
        .mt_sel     (mt_sel),
        .mt_data    (mt_data),
        .hi         (hi),
        .lo         (lo)
    );

    // Shift-add multiplier: samples operands on the first iterate edge,
    // one bit per iterate edge, registers product and clears on out code.
    logic [63:0] m_acc;
    logic [63:0] m_mc;
    logic [63:0] m_dout;
    logic [31:0] m_mp;
    logic        m_run;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc  <= '0;
            m_mc   <= '0;
            m_dout <= '0;
            m_mp   <= '0;
            m_run  <= 1'b0;
        end else if (mul_signal == C_MULTU || mul_signal == C_MADDU) begin
            if (!m_run) begin
                m_run <= 1'b1;
                m_acc <= mul_b[0] ? {32'b0, mul_a} : 64'b0;
                m_mc  <= {31'b0, mul_a, 1'b0};
                m_mp  <= {1'b0, mul_b[31:1]};
            end else begin
                m_acc <= m_acc + (m_mp[0] ? m_mc : 64'b0);
                m_mc  <= m_mc << 1;
                m_mp  <= m_mp >> 1;
            end
        end else if (mul_signal == C_MOUT || mul_signal == C_AOUT) begin
            m_dout <= m_acc;
            m_acc  <= '0;
            m_run  <= 1'b0;
        end
    end

    assign mul_result = m_dout;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic        pre;
        logic [31:0] phi;
        logic [31:0] plo;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered and left at a negedge.
    task automatic mt_write(input logic sel, input logic [31:0] d);
        mt_we   = 1'b1;
        mt_sel  = sel;
        mt_data = d;
        @(negedge clk);
        mt_we = 1'b0;
    endtask

    // Issues one op (optionally with a coincident MT write) and follows it
    // until busy drops; reports done cycle, busy/done counts, drain code.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic mt_en,
                          input logic [31:0] mt_d,
                          output int lat, output int nb, output int nd,
                          output logic [5:0] sig);
        lat = 0;
        nb  = 0;
        nd  = 0;
        sig = 'x;
        req_valid = 1'b1;
        req_funct = f;
        req_a     = a;
        req_b     = b;
        mt_we     = mt_en;
        mt_sel    = 1'b0;
        mt_data   = mt_d;
        @(negedge clk);
        req_valid = 1'b0;
        mt_we     = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (busy) nb++;
            if (done) begin
                lat = n;
                nd++;
            end
            if (n == ITER + 1) sig = mul_signal;
            if (!busy) break;
        end
    endtask

    int         lat;
    int         nb;
    int         nd;
    logic [5:0] sig;

    initial begin
        vt[0] = '{C_MULTU, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0,
                  32'h0, 32'hF};
        vt[1] = '{C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0,
                  32'hFFFFFFFE, 32'h1};
        vt[2] = '{C_MULTU, 32'h0, 32'h12345678, 1'b0, 32'd0, 32'd0,
                  32'h0, 32'h0};
        vt[3] = '{C_MADDU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd10,
                  32'h0, 32'd16};
        vt[4] = '{C_MADDU, 32'd1, 32'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h0, 32'h0};
        vt[5] = '{C_MULTU, 32'h10000, 32'h10000, 1'b0, 32'd0, 32'd0,
                  32'h1, 32'h0};
        vt[6] = '{C_MADDU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'd0,
                  32'h2, 32'hFFFFFFFE};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_funct = '0;
        req_a     = '0;
        req_b     = '0;
        mt_we     = 1'b0;
        mt_sel    = 1'b0;
        mt_data   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        chk("rst ready", req_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sig", mul_signal, C_IDLE);
        chk("rst mul_a", mul_a, 0);
        @(negedge clk);

        // Unsupported funct is ignored
        req_valid = 1'b1;
        req_funct = 6'h18;
        req_a     = 32'd4;
        req_b     = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        chk("bad busy", busy, 0);
        chk("bad done", done, 0);
        chk("bad ready", req_ready, 1);
        repeat (2) @(negedge clk);
        chk("bad busy2", busy, 0);
        chk("bad lo", lo, 0);

        foreach (vt[i]) begin
            if (vt[i].pre) begin
                mt_write(1'b1, vt[i].phi);
                mt_write(1'b0, vt[i].plo);
            end
            run_op(vt[i].f, vt[i].a, vt[i].b, 1'b0, 32'd0,
                   lat, nb, nd, sig);
            chk($sformatf("v%0d done cycle", i), lat, ITER + 2);
            chk($sformatf("v%0d busy cycles", i), nb, ITER + 2);
            chk($sformatf("v%0d done pulses", i), nd, 1);
            chk($sformatf("v%0d drain code", i), sig,
                (vt[i].f == C_MADDU) ? C_AOUT : C_MOUT);
            chk($sformatf("v%0d hi", i), hi, vt[i].ehi);
            chk($sformatf("v%0d lo", i), lo, vt[i].elo);
        end

        // Request and MT write during RUN are both dropped
        req_valid = 1'b1;
        req_funct = C_MULTU;
        req_a     = 32'd4;
        req_b     = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("run sig", mul_signal, C_MULTU);
        chk("run mul_a", mul_a, 32'd4);
        chk("run ready", req_ready, 0);
        req_valid = 1'b1;
        req_funct = C_MADDU;
        req_a     = 32'd9;
        req_b     = 32'd9;
        mt_we     = 1'b1;
        mt_sel    = 1'b0;
        mt_data   = 32'hDEAD;
        @(negedge clk);
        req_valid = 1'b0;
        mt_we     = 1'b0;
        chk("run lo held", lo, 32'hFFFFFFFE);
        chk("run hi held", hi, 32'h2);
        chk("run mul_a held", mul_a, 32'd4);
        for (int n = 0; n < 60; n++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("run finished", busy, 0);
        chk("run hi", hi, 0);
        chk("run lo", lo, 32'd16);
        repeat (3) @(negedge clk);
        chk("run not queued", busy, 0);
        chk("run lo stable", lo, 32'd16);

        // MT write coincident with MADDU accept lands first
        run_op(C_MADDU, 32'd5, 32'd5, 1'b1, 32'd100, lat, nb, nd, sig);
        chk("co done cycle", lat, ITER + 2);
        chk("co hi", hi, 0);
        chk("co lo", lo, 32'd125);

        // Async reset in cycle 10 of MULTU 7 x 9
        req_valid = 1'b1;
        req_funct = C_MULTU;
        req_a     = 32'd7;
        req_b     = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-rst busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid-rst busy", busy, 0);
        chk("mid-rst ready", req_ready, 1);
        chk("mid-rst sig", mul_signal, C_IDLE);
        chk("mid-rst hi", hi, 0);
        chk("mid-rst lo", lo, 0);
        chk("mid-rst mul_b", mul_b, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(C_MULTU, 32'd7, 32'd9, 1'b0, 32'd0, lat, nb, nd, sig);
        chk("post-rst done cycle", lat, ITER + 2);
        chk("post-rst hi", hi, 0);
        chk("post-rst lo", lo, 32'd63);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
